// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: FSM state encoding shared by the arbiter files.
// No ports. Also provides ptr_w(), the width of a requester index.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: requester side and I2C-master side signals.
// master modport = arbiter view; slave modport = requesters + I2C master.
interface i2c_master_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_wr;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_din;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              mst_newd;
    logic              mst_wr;
    logic [6:0]        mst_addr;
    logic [7:0]        mst_din;
    logic [7:0]        mst_dout;
    logic              mst_done;
    logic              mst_nack;

    modport master (
        input  req, req_wr, req_addr, req_din,
        input  mst_dout, mst_done, mst_nack,
        output gnt, rsp_valid, rsp_data, rsp_err,
        output mst_newd, mst_wr, mst_addr, mst_din
    );

    modport slave (
        output req, req_wr, req_addr, req_din,
        output mst_dout, mst_done, mst_nack,
        input  gnt, rsp_valid, rsp_data, rsp_err,
        input  mst_newd, mst_wr, mst_addr, mst_din
    );

endinterface

// File: rtl/i2c_rr_select.sv
// i2c_rr_select: combinational round-robin pick of the first set
// request at or after i_ptr. Ports: i_req, i_ptr -> o_gnt, o_idx, o_any.
module i2c_rr_select
    import i2c_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    logic [PW:0] w_j;

    // Scan NREQ positions starting at i_ptr, wrapping at NREQ.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = {1'b0, i_ptr} + (PW+1)'(i);
            if (w_j >= (PW+1)'(NREQ))
                w_j = w_j - (PW+1)'(NREQ);
            if (!o_any && i_req[w_j[PW-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_j[PW-1:0];
                o_gnt[w_j[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin share of one I2C master among NREQ
// requesters. Ports: clk, rst_n (async, active low), bus (master modport:
// req/req_wr/req_addr/req_din in, gnt/rsp_* out, mst_* to/from the master).
// Optional macro I2C_ARB_TIMEOUT_EN: abort a transaction after TIMEOUT_CYC
// cycles in ARB_WAIT with rsp_err=1.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic                  clk,
    input logic                  rst_n,
    i2c_master_arbiter_if.master bus
);

    localparam int PW = ptr_w(NREQ);

    arb_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_idx;
    logic [NREQ-1:0] r_sel;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic            r_rsp_err;
    logic            r_newd;
    logic            r_wr;
    logic [6:0]      r_addr;
    logic [7:0]      r_din;

    logic [NREQ-1:0] w_sel;
    logic [PW-1:0]   w_idx;
    logic            w_any;
    logic            w_tmo;

    i2c_rr_select #(.NREQ(NREQ)) u_sel (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_sel),
        .o_idx (w_idx),
        .o_any (w_any)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;

    // r_cnt counts completed WAIT cycles; fire on the last one.
    assign w_tmo = (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == ARB_ISSUE)
            r_cnt <= '0;
        else if (r_state == ARB_WAIT)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_sel       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_newd      <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_newd      <= 1'b0;
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_sel;
                        r_sel   <= w_sel;
                        r_idx   <= w_idx;
                        r_wr    <= bus.req_wr[w_idx];
                        r_addr  <= bus.req_addr[7*int'(w_idx) +: 7];
                        r_din   <= bus.req_din[8*int'(w_idx) +: 8];
                        r_state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    r_newd  <= 1'b1;
                    r_state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (bus.mst_done) begin
                        r_rsp_valid <= r_sel;
                        r_rsp_data  <= r_wr ? 8'h00 : bus.mst_dout;
                        r_rsp_err   <= bus.mst_nack;
                        r_state     <= ARB_RESP;
                    end else if (w_tmo) begin
                        r_rsp_valid <= r_sel;
                        r_rsp_data  <= 8'h00;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (r_idx == PW'(NREQ - 1))
                        r_ptr <= '0;
                    else
                        r_ptr <= r_idx + 1'b1;
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mst_newd  = r_newd;
    assign bus.mst_wr    = r_wr;
    assign bus.mst_addr  = r_addr;
    assign bus.mst_din   = r_din;

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one I2C master (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 4096, maximum cycles to wait for mst_done.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester transaction request; level, held until gnt.
REQ-006 req_wr  input  NREQ  per-requester direction: 1 write, 0 read.
REQ-007 req_addr  input  7*NREQ  per-requester 7-bit slave address, packed, requester 0 at LSBs.
REQ-008 req_din  input  8*NREQ  per-requester write byte, packed.
REQ-009 gnt  output  NREQ  one-hot single-cycle pulse: request accepted and operands captured.
REQ-010 rsp_valid  output  NREQ  one-hot single-cycle pulse: transaction finished.
REQ-011 rsp_data  output  8  read byte; valid with rsp_valid; 0 for writes.
REQ-012 rsp_err  output  1  NACK or timeout; valid with rsp_valid.
REQ-013 mst_newd  output  1  single-cycle start pulse to the I2C master.
REQ-014 mst_wr, mst_addr, mst_din  output  1/7/8  operands to the master.
REQ-015 mst_dout  input  8  read data from the master.
REQ-016 mst_done  input  1  master transaction complete pulse.
REQ-017 mst_nack  input  1  slave NACK flag, sampled with mst_done.

Function
REQ-018 FSM states SHALL be ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP.
REQ-019 ARB_IDLE: if any req bit set, the arbiter SHALL select the first set bit at or after rr_ptr (round-robin, wrapping at NREQ-1 -> 0), pulse gnt for it, latch its wr/addr/din and index, and go to ARB_ISSUE the next cycle.
REQ-020 ARB_ISSUE: mst_newd SHALL be 1 for exactly one cycle, then ARB_WAIT.
REQ-021 mst_wr/mst_addr/mst_din SHALL stay constant from ARB_ISSUE until leaving ARB_WAIT; they are driven only from latched registers.
REQ-022 ARB_WAIT: on mst_done, the arbiter SHALL capture mst_dout (reads only) and mst_nack into rsp registers and go to ARB_RESP.
REQ-023 ARB_RESP: rsp_valid SHALL pulse for the latched index for one cycle; rr_ptr SHALL become (index+1) mod NREQ; next state ARB_IDLE.
REQ-024 Latency: gnt to mst_newd is 1 cycle; mst_done to rsp_valid is 1 cycle; back-to-back grants are at least 4 cycles apart.
REQ-025 Requests arriving or deasserting outside ARB_IDLE SHALL be ignored; latched operands are unaffected.
REQ-026 mst_done outside ARB_WAIT SHALL be ignored.
REQ-027 With all req set continuously, each requester SHALL be granted once per NREQ transactions.

Reset
REQ-028 On rst_n low, state SHALL be ARB_IDLE, rr_ptr 0, and gnt, rsp_valid, rsp_data, rsp_err, mst_newd, mst_wr, mst_addr, mst_din all 0, immediately and independent of clk.
REQ-029 Reset mid-transaction SHALL drop the transaction with no rsp_valid; the master is reset by the same rst_n.

Configuration
REQ-030 Macro I2C_ARB_TIMEOUT_EN defined: a cycle counter SHALL clear in ARB_ISSUE, increment in ARB_WAIT, and on reaching TIMEOUT_CYC without mst_done force ARB_RESP with rsp_err=1, rsp_data=0.
REQ-031 Macro undefined: no counter is built; ARB_WAIT SHALL wait indefinitely for mst_done.

Structure
REQ-032 Package i2c_arb_pkg SHALL hold the state enum type and state encodings (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
REQ-033 Sub-module i2c_rr_select SHALL implement the combinational round-robin pick (req, rr_ptr -> one-hot grant, index, any).

Verification
REQ-034 Single write: req[2]=1, wr=1, addr=0x50, din=0xA5 -> gnt[2] pulse, mst_newd next cycle, mst_addr=0x50, mst_din=0xA5 held until mst_done, rsp_valid[2] with rsp_err=0.
REQ-035 Read: req[0] read addr 0x68, mst_dout=0x3C with mst_done -> rsp_valid[0], rsp_data=0x3C one cycle later.
REQ-036 Fairness: req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-037 NACK: mst_done with mst_nack=1 -> rsp_err=1 to the granted requester.
REQ-038 Timeout (macro on, TIMEOUT_CYC=16): no mst_done -> rsp_valid with rsp_err=1 exactly 16 cycles after entering ARB_WAIT; macro off -> still in ARB_WAIT after 10000 cycles.
REQ-039 Reset in ARB_WAIT: rst_n low -> all outputs 0 asynchronously, no rsp_valid, first grant after reset goes to lowest set req index.
